// File: rtl/rv32_pkg.sv
// Shared encodings for the RV32I execute stage: control-field codes, ALU operation enum
// and funct3 constants used by the ALU decode and branch compare.
package rv32_pkg;

  // decode_alu_op encodings
  localparam logic [1:0] AluOpAdd    = 2'b00;
  localparam logic [1:0] AluOpBranch = 2'b01;
  localparam logic [1:0] AluOpFunct3 = 2'b10;

  // decode_result_src encodings (consumed in WB, piped through here)
  localparam logic [1:0] ResultAlu     = 2'b00;
  localparam logic [1:0] ResultLoad    = 2'b01;
  localparam logic [1:0] ResultPcPlus4 = 2'b10;

  // decode_lui_auipc encodings
  localparam logic [1:0] LuiAuipcNone  = 2'b00;
  localparam logic [1:0] LuiAuipcLui   = 2'b01;
  localparam logic [1:0] LuiAuipcAuipc = 2'b10;

  typedef enum logic [3:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluXor,
    AluSll,
    AluSrl,
    AluSra,
    AluSlt,
    AluSltu
  } alu_op_e;

  // OP / OP-IMM funct3 values
  localparam logic [2:0] Funct3AddSub = 3'b000;
  localparam logic [2:0] Funct3Sll    = 3'b001;
  localparam logic [2:0] Funct3Slt    = 3'b010;
  localparam logic [2:0] Funct3Sltu   = 3'b011;
  localparam logic [2:0] Funct3Xor    = 3'b100;
  localparam logic [2:0] Funct3SrlSra = 3'b101;
  localparam logic [2:0] Funct3Or     = 3'b110;
  localparam logic [2:0] Funct3And    = 3'b111;

  // Branch funct3 values
  localparam logic [2:0] Funct3Beq  = 3'b000;
  localparam logic [2:0] Funct3Bne  = 3'b001;
  localparam logic [2:0] Funct3Blt  = 3'b100;
  localparam logic [2:0] Funct3Bge  = 3'b101;
  localparam logic [2:0] Funct3Bltu = 3'b110;
  localparam logic [2:0] Funct3Bgeu = 3'b111;

endpackage

// File: rtl/rv32_alu.sv
// Combinational RV32I ALU: result = op(a, b). Shifts use b[4:0]; arithmetic wraps.
module rv32_alu
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  // Operation select
  always_comb begin
    result = '0;
    unique case (op)
      AluAdd:  result = a + b;
      AluSub:  result = a - b;
      AluAnd:  result = a & b;
      AluOr:   result = a | b;
      AluXor:  result = a ^ b;
      AluSll:  result = a << shamt;
      AluSrl:  result = a >> shamt;
      AluSra:  result = $unsigned($signed(a) >>> shamt);
      AluSlt:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      AluSltu: result = {{(XLEN-1){1'b0}}, a < b};
      default: result = a + b;
    endcase
  end

endmodule

// File: rtl/rv32_execute_stage.sv
// RV32I execute stage: operand bypass, ALU, branch/jump resolution and EX/MEM registers.
// Optional feature macro EXEC_FWD_EN enables the MEM/WB bypass network; without it the
// operands come straight from the register file read data.
module rv32_execute_stage
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [4:0]      decode_rs1,
  input  logic [4:0]      decode_rs2,
  input  logic [4:0]      decode_rd,
  input  logic [XLEN-1:0] rs_data1,
  input  logic [XLEN-1:0] rs_data2,
  input  logic [XLEN-1:0] decode_imm,
  input  logic [XLEN-1:0] decode_instr_addr,
  input  logic [XLEN-1:0] decode_instr_addr_plus,
  input  logic [1:0]      decode_alu_op,
  input  logic [2:0]      decode_funct3,
  input  logic            decode_funct7b5,
  input  logic            decode_alu_src,
  input  logic [1:0]      decode_lui_auipc,
  input  logic            decode_jump,
  input  logic            decode_jal_src,
  input  logic            decode_branch,
  input  logic            decode_regfile_wr_enable,
  input  logic            decode_datamem_wr_enable,
  input  logic [1:0]      decode_result_src,
  input  logic [4:0]      mem_rd,
  input  logic [4:0]      wb_rd,
  input  logic            mem_regfile_wr_enable,
  input  logic            wb_regfile_wr_enable,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] wb_write_data,
  output logic            execute_pc_src,
  output logic            execute_jal_src,
  output logic [XLEN-1:0] jal_instr_addr,
  output logic [XLEN-1:0] jalr_instr_addr,
  output logic [4:0]      execute_rd,
  output logic            execute_regfile_wr_enable,
  output logic            execute_datamem_wr_enable,
  output logic [1:0]      execute_result_src,
  output logic [2:0]      execute_funct3,
  output logic [XLEN-1:0] execute_alu_result,
  output logic [XLEN-1:0] execute_wr_datamem_data,
  output logic [XLEN-1:0] execute_instr_addr_plus
);

  logic [XLEN-1:0] fwd_a, fwd_b, alu_b, alu_out, result, jalr_sum;
  alu_op_e         alu_sel;
  logic            taken;

`ifdef EXEC_FWD_EN
  // Operand bypass: MEM has priority over WB; x0 is never bypassed
  always_comb begin
    fwd_a = rs_data1;
    fwd_b = rs_data2;
    if (mem_regfile_wr_enable && mem_rd == decode_rs1 && decode_rs1 != 5'd0) begin
      fwd_a = mem_alu_result;
    end else if (wb_regfile_wr_enable && wb_rd == decode_rs1 && decode_rs1 != 5'd0) begin
      fwd_a = wb_write_data;
    end
    if (mem_regfile_wr_enable && mem_rd == decode_rs2 && decode_rs2 != 5'd0) begin
      fwd_b = mem_alu_result;
    end else if (wb_regfile_wr_enable && wb_rd == decode_rs2 && decode_rs2 != 5'd0) begin
      fwd_b = wb_write_data;
    end
  end
`else
  // No bypass network: operands are the register file read data
  always_comb begin
    fwd_a = rs_data1;
    fwd_b = rs_data2;
  end

  logic unused_fwd;
  assign unused_fwd = ^{decode_rs1, decode_rs2, mem_rd, wb_rd, mem_regfile_wr_enable,
                        wb_regfile_wr_enable, mem_alu_result, wb_write_data};
`endif

  assign alu_b = decode_alu_src ? decode_imm : fwd_b;

  // ALU operation decode from alu_op / funct3 / funct7b5
  always_comb begin
    alu_sel = AluAdd;
    case (decode_alu_op)
      AluOpAdd:    alu_sel = AluAdd;
      AluOpBranch: alu_sel = AluSub;
      AluOpFunct3: begin
        case (decode_funct3)
          Funct3AddSub: alu_sel = (decode_funct7b5 && !decode_alu_src) ? AluSub : AluAdd;
          Funct3Sll:    alu_sel = AluSll;
          Funct3Slt:    alu_sel = AluSlt;
          Funct3Sltu:   alu_sel = AluSltu;
          Funct3Xor:    alu_sel = AluXor;
          Funct3SrlSra: alu_sel = decode_funct7b5 ? AluSra : AluSrl;
          Funct3Or:     alu_sel = AluOr;
          default:      alu_sel = AluAnd;
        endcase
      end
      default:     alu_sel = AluAdd;
    endcase
  end

  rv32_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .a      (fwd_a),
    .b      (alu_b),
    .op     (alu_sel),
    .result (alu_out)
  );

  // Result mux: LUI / AUIPC bypass the ALU
  always_comb begin
    result = alu_out;
    case (decode_lui_auipc)
      LuiAuipcLui:   result = decode_imm;
      LuiAuipcAuipc: result = decode_instr_addr + decode_imm;
      default:       result = alu_out;
    endcase
  end

  // Branch condition on the bypassed operands; funct3 010/011 never taken
  always_comb begin
    taken = 1'b0;
    case (decode_funct3)
      Funct3Beq:  taken = fwd_a == fwd_b;
      Funct3Bne:  taken = fwd_a != fwd_b;
      Funct3Blt:  taken = $signed(fwd_a) < $signed(fwd_b);
      Funct3Bge:  taken = $signed(fwd_a) >= $signed(fwd_b);
      Funct3Bltu: taken = fwd_a < fwd_b;
      Funct3Bgeu: taken = fwd_a >= fwd_b;
      default:    taken = 1'b0;
    endcase
  end

  assign jalr_sum        = fwd_a + decode_imm;
  assign jalr_instr_addr = jalr_sum & {{(XLEN-1){1'b1}}, 1'b0};
  assign jal_instr_addr  = decode_instr_addr + decode_imm;
  assign execute_pc_src  = decode_jump | (decode_branch & taken);
  assign execute_jal_src = decode_jal_src;

  // EX/MEM pipeline registers; reset turns the slot into a NOP
  always_ff @(posedge clk) begin
    if (!rstn) begin
      execute_rd                <= '0;
      execute_regfile_wr_enable <= 1'b0;
      execute_datamem_wr_enable <= 1'b0;
      execute_result_src        <= '0;
      execute_funct3            <= '0;
      execute_alu_result        <= '0;
      execute_wr_datamem_data   <= '0;
      execute_instr_addr_plus   <= '0;
    end else begin
      execute_rd                <= decode_rd;
      execute_regfile_wr_enable <= decode_regfile_wr_enable;
      execute_datamem_wr_enable <= decode_datamem_wr_enable;
      execute_result_src        <= decode_result_src;
      execute_funct3            <= decode_funct3;
      execute_alu_result        <= result;
      execute_wr_datamem_data   <= fwd_b;
      execute_instr_addr_plus   <= decode_instr_addr_plus;
    end
  end

endmodule

// File: tb/tb_rv32_execute_stage.sv
// Self-checking bench for rv32_execute_stage: directed cases plus randomized instructions
// compared against a behavioural model. Honors EXEC_FWD_EN the same way the design does.
module tb_rv32_execute_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic [4:0]  decode_rs1, decode_rs2, decode_rd, mem_rd, wb_rd;
  logic [31:0] rs_data1, rs_data2, decode_imm, decode_instr_addr, decode_instr_addr_plus;
  logic [1:0]  decode_alu_op, decode_lui_auipc, decode_result_src;
  logic [2:0]  decode_funct3;
  logic        decode_funct7b5, decode_alu_src, decode_jump, decode_jal_src, decode_branch;
  logic        decode_regfile_wr_enable, decode_datamem_wr_enable;
  logic        mem_regfile_wr_enable, wb_regfile_wr_enable;
  logic [31:0] mem_alu_result, wb_write_data;
  logic        execute_pc_src, execute_jal_src;
  logic [31:0] jal_instr_addr, jalr_instr_addr;
  logic [4:0]  execute_rd;
  logic        execute_regfile_wr_enable, execute_datamem_wr_enable;
  logic [1:0]  execute_result_src;
  logic [2:0]  execute_funct3;
  logic [31:0] execute_alu_result, execute_wr_datamem_data, execute_instr_addr_plus;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected values from the model
  logic        exp_pc_src, exp_jal_src;
  logic [31:0] exp_jal, exp_jalr;
  logic [4:0]  exp_rd;
  logic        exp_rwe, exp_dwe;
  logic [1:0]  exp_rsrc;
  logic [2:0]  exp_f3;
  logic [31:0] exp_res, exp_sdata, exp_pcp;

  always #5 clk = ~clk;

  rv32_execute_stage dut (
    .clk                       (clk),
    .rstn                      (rstn),
    .decode_rs1                (decode_rs1),
    .decode_rs2                (decode_rs2),
    .decode_rd                 (decode_rd),
    .rs_data1                  (rs_data1),
    .rs_data2                  (rs_data2),
    .decode_imm                (decode_imm),
    .decode_instr_addr         (decode_instr_addr),
    .decode_instr_addr_plus    (decode_instr_addr_plus),
    .decode_alu_op             (decode_alu_op),
    .decode_funct3             (decode_funct3),
    .decode_funct7b5           (decode_funct7b5),
    .decode_alu_src            (decode_alu_src),
    .decode_lui_auipc          (decode_lui_auipc),
    .decode_jump               (decode_jump),
    .decode_jal_src            (decode_jal_src),
    .decode_branch             (decode_branch),
    .decode_regfile_wr_enable  (decode_regfile_wr_enable),
    .decode_datamem_wr_enable  (decode_datamem_wr_enable),
    .decode_result_src         (decode_result_src),
    .mem_rd                    (mem_rd),
    .wb_rd                     (wb_rd),
    .mem_regfile_wr_enable     (mem_regfile_wr_enable),
    .wb_regfile_wr_enable      (wb_regfile_wr_enable),
    .mem_alu_result            (mem_alu_result),
    .wb_write_data             (wb_write_data),
    .execute_pc_src            (execute_pc_src),
    .execute_jal_src           (execute_jal_src),
    .jal_instr_addr            (jal_instr_addr),
    .jalr_instr_addr           (jalr_instr_addr),
    .execute_rd                (execute_rd),
    .execute_regfile_wr_enable (execute_regfile_wr_enable),
    .execute_datamem_wr_enable (execute_datamem_wr_enable),
    .execute_result_src        (execute_result_src),
    .execute_funct3            (execute_funct3),
    .execute_alu_result        (execute_alu_result),
    .execute_wr_datamem_data   (execute_wr_datamem_data),
    .execute_instr_addr_plus   (execute_instr_addr_plus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Value seen by an instruction reading register rs
  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
`ifdef EXEC_FWD_EN
    if (rs != 0 && mem_regfile_wr_enable && mem_rd == rs) return mem_alu_result;
    if (rs != 0 && wb_regfile_wr_enable && wb_rd == rs) return wb_write_data;
`endif
    return rf;
  endfunction

  task automatic model();
    logic [31:0] a, b, bb, alu;
    logic        tk;
    a  = operand(decode_rs1, rs_data1);
    b  = operand(decode_rs2, rs_data2);
    bb = decode_alu_src ? decode_imm : b;
    if (decode_alu_op == 2'd0) alu = a + bb;
    else if (decode_alu_op == 2'd1) alu = a - bb;
    else begin
      case (decode_funct3)
        3'd0: alu = (decode_funct7b5 && !decode_alu_src) ? a - bb : a + bb;
        3'd1: alu = a << bb[4:0];
        3'd2: alu = ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
        3'd3: alu = (a < bb) ? 32'd1 : 32'd0;
        3'd4: alu = a ^ bb;
        3'd5: alu = decode_funct7b5 ? 32'($signed(a) >>> bb[4:0]) : a >> bb[4:0];
        3'd6: alu = a | bb;
        default: alu = a & bb;
      endcase
    end
    if (decode_lui_auipc == 2'd1) alu = decode_imm;
    else if (decode_lui_auipc == 2'd2) alu = decode_instr_addr + decode_imm;
    case (decode_funct3)
      3'd0: tk = (a == b);
      3'd1: tk = (a != b);
      3'd4: tk = ($signed(a) < $signed(b));
      3'd5: tk = ($signed(a) >= $signed(b));
      3'd6: tk = (a < b);
      3'd7: tk = (a >= b);
      default: tk = 1'b0;
    endcase
    exp_pc_src  = decode_jump || (decode_branch && tk);
    exp_jal_src = decode_jal_src;
    exp_jal     = decode_instr_addr + decode_imm;
    exp_jalr    = (a + decode_imm) & 32'hFFFF_FFFE;
    if (!rstn) begin
      {exp_rd, exp_rwe, exp_dwe, exp_rsrc, exp_f3} = '0;
      {exp_res, exp_sdata, exp_pcp} = '0;
    end else begin
      exp_rd = decode_rd; exp_rwe = decode_regfile_wr_enable;
      exp_dwe = decode_datamem_wr_enable; exp_rsrc = decode_result_src;
      exp_f3 = decode_funct3; exp_res = alu; exp_sdata = b; exp_pcp = decode_instr_addr_plus;
    end
  endtask

  // Check combinational outputs, clock once, then check the EX/MEM registers
  task automatic step();
    #1;
    model();
    check("pc_src", 32'(execute_pc_src), 32'(exp_pc_src));
    check("jal_src", 32'(execute_jal_src), 32'(exp_jal_src));
    check("jal_addr", jal_instr_addr, exp_jal);
    check("jalr_addr", jalr_instr_addr, exp_jalr);
    @(posedge clk);
    #1;
    check("rd", 32'(execute_rd), 32'(exp_rd));
    check("rf_we", 32'(execute_regfile_wr_enable), 32'(exp_rwe));
    check("dm_we", 32'(execute_datamem_wr_enable), 32'(exp_dwe));
    check("res_src", 32'(execute_result_src), 32'(exp_rsrc));
    check("funct3", 32'(execute_funct3), 32'(exp_f3));
    check("alu_result", execute_alu_result, exp_res);
    check("store_data", execute_wr_datamem_data, exp_sdata);
    check("pc_plus4", execute_instr_addr_plus, exp_pcp);
  endtask

  task automatic clear();
    rstn = 1'b1;
    {decode_rs1, decode_rs2, decode_rd, mem_rd, wb_rd} = '0;
    {rs_data1, rs_data2, decode_imm, decode_instr_addr, decode_instr_addr_plus} = '0;
    {decode_alu_op, decode_lui_auipc, decode_result_src, decode_funct3} = '0;
    {decode_funct7b5, decode_alu_src, decode_jump, decode_jal_src, decode_branch} = '0;
    {decode_regfile_wr_enable, decode_datamem_wr_enable} = '0;
    {mem_regfile_wr_enable, wb_regfile_wr_enable, mem_alu_result, wb_write_data} = '0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // Reset with non-zero inputs: registers must still clear
    clear();
    decode_rd = 5'd7; decode_regfile_wr_enable = 1'b1; rs_data1 = 32'd9;
    decode_instr_addr_plus = 32'h44;
    rstn = 1'b0;
    step();
    check("reset_alu_const", execute_alu_result, 32'd0);

    // add x3, x1, x2
    clear();
    decode_rs1 = 5'd1; decode_rs2 = 5'd2; decode_rd = 5'd3;
    rs_data1 = 32'd5; rs_data2 = 32'd7; decode_regfile_wr_enable = 1'b1;
    step();
    check("add_const", execute_alu_result, 32'd12);

    // Dependency through MEM and WB on rs1 = 3, then rs1 = 0
    clear();
    decode_rs1 = 5'd3; rs_data1 = 32'd1; decode_rd = 5'd4; decode_regfile_wr_enable = 1'b1;
    mem_rd = 5'd3; mem_regfile_wr_enable = 1'b1; mem_alu_result = 32'd100;
    wb_rd = 5'd3; wb_regfile_wr_enable = 1'b1; wb_write_data = 32'd50;
    step();
    decode_rs1 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
    step();
    check("rs1_zero_const", execute_alu_result, 32'd1);

    // beq taken / not taken
    clear();
    decode_branch = 1'b1; decode_jal_src = 1'b1; decode_alu_op = 2'b01;
    decode_instr_addr = 32'h40; decode_imm = 32'h10; rs_data1 = 32'd8; rs_data2 = 32'd8;
    step();
    check("beq_taken_const", 32'(execute_pc_src), 32'd1);
    check("beq_target_const", jal_instr_addr, 32'h50);
    rs_data2 = 32'd9;
    step();
    check("beq_not_taken_const", 32'(execute_pc_src), 32'd0);

    // jalr
    clear();
    decode_jump = 1'b1; decode_rs1 = 5'd5; rs_data1 = 32'h1003; decode_imm = 32'd4;
    decode_instr_addr = 32'h200; decode_instr_addr_plus = 32'h204; decode_result_src = 2'b10;
    decode_regfile_wr_enable = 1'b1; decode_rd = 5'd1; decode_alu_src = 1'b1;
    step();
    check("jalr_target_const", jalr_instr_addr, 32'h1006);
    check("jalr_pcplus_const", execute_instr_addr_plus, 32'h204);

    // srai and sltu
    clear();
    decode_alu_op = 2'b10; decode_funct3 = 3'b101; decode_funct7b5 = 1'b1;
    decode_alu_src = 1'b1; rs_data1 = 32'h8000_0000; decode_imm = 32'd4;
    step();
    check("srai_const", execute_alu_result, 32'hF800_0000);
    decode_funct3 = 3'b011; decode_funct7b5 = 1'b0; decode_alu_src = 1'b0;
    rs_data1 = 32'd1; rs_data2 = 32'hFFFF_FFFF;
    step();
    check("sltu_const", execute_alu_result, 32'd1);

    // Randomized instructions, with occasional mid-stream reset
    for (int i = 0; i < 400; i++) begin
      rstn = ($urandom_range(0, 19) != 0);
      decode_rs1 = 5'($urandom_range(0, 3)); decode_rs2 = 5'($urandom_range(0, 3));
      decode_rd = 5'($urandom); mem_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
      rs_data1 = pick(); rs_data2 = ($urandom_range(0, 3) == 0) ? rs_data1 : pick();
      decode_imm = pick(); decode_instr_addr = $urandom; decode_instr_addr_plus = $urandom;
      decode_alu_op = 2'($urandom_range(0, 2)); decode_funct3 = 3'($urandom);
      decode_funct7b5 = 1'($urandom); decode_alu_src = 1'($urandom);
      decode_lui_auipc = 2'($urandom_range(0, 2)); decode_jump = ($urandom_range(0, 5) == 0);
      decode_jal_src = 1'($urandom); decode_branch = 1'($urandom);
      decode_regfile_wr_enable = 1'($urandom); decode_datamem_wr_enable = 1'($urandom);
      decode_result_src = 2'($urandom_range(0, 2));
      mem_regfile_wr_enable = 1'($urandom); wb_regfile_wr_enable = 1'($urandom);
      mem_alu_result = pick(); wb_write_data = pick();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
